hier_icache_bank_ctrl_responder: RTL and testbench

Per-bank responder for the shared-icache control bus driven by the icache control unit. It lives inside each shared L1.5 cache bank and serves enable, disable, full-flush and selective-flush requests. It stalls fetch, waits for the bank pipeline to drain, and invalidates tag sets through the tag-array write port. It acknowledges each request with a one-cycle pulse.

---
 rtl/hier_icache_bank_ctrl_responder_if.sv | 86 ++++++++
 rtl/hier_icache_bank_ctrl_responder.sv | 201 ++++++++++++++++++++
 tb/tb_hier_icache_bank_ctrl_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hier_icache_bank_ctrl_responder_if.sv
// ---------------------------------------------------------------------------
// hier_icache_bank_ctrl_responder_if
//
// Purpose:
//   Groups the control-bus handshake, the bank status input and the
//   tag-array invalidate write port of one shared L1.5 icache bank responder.
//
// Parameters:
//   NB_WAYS : ways per set, width of the way-enable mask
//   NB_SETS : sets per bank (power of 2)
//
// Signals (direction as seen by the responder, i.e. the slave modport):
//   ctrl_req_enable_i  / ctrl_ack_enable_o   enable request / ack pulse
//   ctrl_req_disable_i / ctrl_ack_disable_o  disable request / ack pulse
//   ctrl_flush_req_i   / ctrl_flush_ack_o    full-flush request / ack pulse
//   sel_flush_req_i    / sel_flush_ack_o     selective-flush request / ack pulse
//   sel_flush_addr_i                         selective-flush address
//   bank_idle_i                              bank fetch pipeline drained
//   fetch_hold_o                             block new fetch lookups
//   cache_enabled_o                          1 = cached, 0 = bypass
//   tag_inv_req_o / tag_inv_set_o /
//   tag_inv_way_be_o / tag_inv_gnt_i         tag invalidate write port
// ---------------------------------------------------------------------------
interface hier_icache_bank_ctrl_responder_if #(
    parameter int NB_WAYS = 4,
    parameter int NB_SETS = 32
);
    localparam int SET_ID_WIDTH = $clog2(NB_SETS);

    logic                    ctrl_req_enable_i;
    logic                    ctrl_ack_enable_o;
    logic                    ctrl_req_disable_i;
    logic                    ctrl_ack_disable_o;
    logic                    ctrl_flush_req_i;
    logic                    ctrl_flush_ack_o;
    logic                    sel_flush_req_i;
    logic                    sel_flush_ack_o;
    logic [31:0]             sel_flush_addr_i;
    logic                    bank_idle_i;
    logic                    fetch_hold_o;
    logic                    cache_enabled_o;
    logic                    tag_inv_req_o;
    logic [SET_ID_WIDTH-1:0] tag_inv_set_o;
    logic [NB_WAYS-1:0]      tag_inv_way_be_o;
    logic                    tag_inv_gnt_i;

    // Responder side.
    modport slave (
        input  ctrl_req_enable_i,
        input  ctrl_req_disable_i,
        input  ctrl_flush_req_i,
        input  sel_flush_req_i,
        input  sel_flush_addr_i,
        input  bank_idle_i,
        input  tag_inv_gnt_i,
        output ctrl_ack_enable_o,
        output ctrl_ack_disable_o,
        output ctrl_flush_ack_o,
        output sel_flush_ack_o,
        output fetch_hold_o,
        output cache_enabled_o,
        output tag_inv_req_o,
        output tag_inv_set_o,
        output tag_inv_way_be_o
    );

    // Control unit / bank / tag array side.
    modport master (
        output ctrl_req_enable_i,
        output ctrl_req_disable_i,
        output ctrl_flush_req_i,
        output sel_flush_req_i,
        output sel_flush_addr_i,
        output bank_idle_i,
        output tag_inv_gnt_i,
        input  ctrl_ack_enable_o,
        input  ctrl_ack_disable_o,
        input  ctrl_flush_ack_o,
        input  sel_flush_ack_o,
        input  fetch_hold_o,
        input  cache_enabled_o,
        input  tag_inv_req_o,
        input  tag_inv_set_o,
        input  tag_inv_way_be_o
    );
endinterface

// File: rtl/hier_icache_bank_ctrl_responder.sv
// ---------------------------------------------------------------------------
// hier_icache_bank_ctrl_responder
//
// Purpose:
//   Per-bank responder for the shared-icache control bus. Serves enable,
//   disable, full-flush and selective-flush requests: holds fetch, waits for
//   the bank pipeline to drain, invalidates tag sets through the tag-array
//   write port and answers each request with a one-cycle ack pulse.
//
// Parameters:
//   NB_WAYS     : ways per set (width of the way-enable mask)
//   NB_SETS     : sets per bank, power of 2
//   LINE_OFFSET : byte-offset bits of a line; set = addr[LINE_OFFSET +: log2(NB_SETS)]
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : hier_icache_bank_ctrl_responder_if.slave (requests/acks, bank
//             idle, fetch hold, cache enable, tag invalidate port)
// ---------------------------------------------------------------------------
module hier_icache_bank_ctrl_responder #(
    parameter int NB_WAYS     = 4,
    parameter int NB_SETS     = 32,
    parameter int LINE_OFFSET = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    hier_icache_bank_ctrl_responder_if.slave      bus
);

    localparam int SET_ID_WIDTH = $clog2(NB_SETS);
    localparam logic [SET_ID_WIDTH-1:0] LAST_SET = SET_ID_WIDTH'(NB_SETS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WALK,
        ST_SEL_INV,
        ST_ACK
    } state_t;

    // Encoding doubles as the bit position of the matching ack output.
    typedef enum logic [1:0] {
        OP_ENABLE    = 2'd0,
        OP_DISABLE   = 2'd1,
        OP_FLUSH     = 2'd2,
        OP_SEL_FLUSH = 2'd3
    } op_t;

    state_t                  r_state;
    op_t                     r_op;
    logic                    r_enabled;
    logic                    r_hold;
    logic                    r_tagReq;
    logic [SET_ID_WIDTH-1:0] r_tagSet;
    logic [SET_ID_WIDTH-1:0] r_selSet;
    logic [3:0]              r_ack;

    logic                    w_reqValid;
    op_t                     w_reqOp;
    logic                    w_trivial;
    logic [SET_ID_WIDTH-1:0] w_addrSet;
    logic                    w_unused_addr;

    // One-hot ack vector {sel, flush, disable, enable} for an operation.
    function automatic logic [3:0] ackOneHot(input op_t op);
        return 4'b0001 << op;
    endfunction

    // Cache-enable value after an operation completes; flushes keep it.
    function automatic logic nextEnabled(input op_t op, input logic cur);
        case (op)
            OP_ENABLE:  return 1'b1;
            OP_DISABLE: return 1'b0;
            default:    return cur;
        endcase
    endfunction

    // Fixed-priority pick among pending requests. A request is trivial when
    // it would not change anything: enabling an enabled bank, disabling a
    // disabled one, or flushing while disabled (the array is invalidated on
    // every enable, so its contents are already dead).
    always_comb begin
        w_reqValid = bus.ctrl_flush_req_i | bus.sel_flush_req_i |
                     bus.ctrl_req_disable_i | bus.ctrl_req_enable_i;
        w_reqOp = OP_ENABLE;
        if (bus.ctrl_flush_req_i) begin
            w_reqOp = OP_FLUSH;
        end else if (bus.sel_flush_req_i) begin
            w_reqOp = OP_SEL_FLUSH;
        end else if (bus.ctrl_req_disable_i) begin
            w_reqOp = OP_DISABLE;
        end
        w_trivial = (w_reqOp == OP_ENABLE) ? r_enabled : ~r_enabled;
    end

    assign w_addrSet     = bus.sel_flush_addr_i[LINE_OFFSET +: SET_ID_WIDTH];
    assign w_unused_addr = ^bus.sel_flush_addr_i;

    // Control FSM; every output is a register written here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_ENABLE;
            r_enabled <= 1'b0;
            r_hold    <= 1'b0;
            r_tagReq  <= 1'b0;
            r_tagSet  <= '0;
            r_selSet  <= '0;
            r_ack     <= 4'b0000;
        end else begin
            r_ack <= 4'b0000;
            case (r_state)
                ST_IDLE: begin
                    if (w_reqValid) begin
                        r_op   <= w_reqOp;
                        r_hold <= 1'b1;
                        if (w_trivial) begin
                            r_state   <= ST_ACK;
                            r_ack     <= ackOneHot(w_reqOp);
                            r_enabled <= nextEnabled(w_reqOp, r_enabled);
                        end else begin
                            r_state <= ST_WAIT_IDLE;
                            if (w_reqOp == OP_SEL_FLUSH) begin
                                r_selSet <= w_addrSet;
                            end
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (bus.bank_idle_i) begin
                        case (r_op)
                            OP_DISABLE: begin
                                r_state   <= ST_ACK;
                                r_ack     <= ackOneHot(r_op);
                                r_enabled <= 1'b0;
                            end
                            OP_SEL_FLUSH: begin
                                r_state  <= ST_SEL_INV;
                                r_tagReq <= 1'b1;
                                r_tagSet <= r_selSet;
                            end
                            default: begin
                                r_state  <= ST_WALK;
                                r_tagReq <= 1'b1;
                                r_tagSet <= '0;
                            end
                        endcase
                    end
                end

                // The set register is the walk counter; NB_SETS is a power
                // of 2 so the increment after the last set wraps to 0.
                ST_WALK: begin
                    if (bus.tag_inv_gnt_i) begin
                        r_tagSet <= r_tagSet + 1'b1;
                        if (r_tagSet == LAST_SET) begin
                            r_state   <= ST_ACK;
                            r_tagReq  <= 1'b0;
                            r_ack     <= ackOneHot(r_op);
                            r_enabled <= nextEnabled(r_op, r_enabled);
                        end
                    end
                end

                ST_SEL_INV: begin
                    if (bus.tag_inv_gnt_i) begin
                        r_state  <= ST_ACK;
                        r_tagReq <= 1'b0;
                        r_tagSet <= '0;
                        r_ack    <= ackOneHot(r_op);
                    end
                end

                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b0;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_hold   <= 1'b0;
                    r_tagReq <= 1'b0;
                    r_tagSet <= '0;
                end
            endcase
        end
    end

    assign bus.ctrl_ack_enable_o  = r_ack[0];
    assign bus.ctrl_ack_disable_o = r_ack[1];
    assign bus.ctrl_flush_ack_o   = r_ack[2];
    assign bus.sel_flush_ack_o    = r_ack[3];
    assign bus.fetch_hold_o       = r_hold;
    assign bus.cache_enabled_o    = r_enabled;
    assign bus.tag_inv_req_o      = r_tagReq;
    assign bus.tag_inv_set_o      = r_tagSet;
    assign bus.tag_inv_way_be_o   = '1;

endmodule

// File: tb/tb_hier_icache_bank_ctrl_responder.sv
// ---------------------------------------------------------------------------
// tb_hier_icache_bank_ctrl_responder
//
// Drives requests as the control unit would (held until ack, dropped the
// cycle after), plays the bank (bank_idle) and the tag array (gnt), and
// predicts each served request from the block's rules: which request wins,
// whether it is trivial, which sets get invalidated, when the ack arrives
// and what the cache-enable state becomes.
// ---------------------------------------------------------------------------
module tb_hier_icache_bank_ctrl_responder;

    localparam int NB_WAYS     = 4;
    localparam int NB_SETS     = 32;
    localparam int LINE_OFFSET = 4;
    localparam int SET_W       = $clog2(NB_SETS);
    localparam int BUDGET      = 400;

    logic clk = 1'b0;
    logic rstN;
    int   checkCount = 0;
    int   passCount  = 0;
    bit   modelEnabled = 1'b0;

    always #5 clk = ~clk;

    hier_icache_bank_ctrl_responder_if #(.NB_WAYS(NB_WAYS), .NB_SETS(NB_SETS)) bus ();

    hier_icache_bank_ctrl_responder #(
        .NB_WAYS(NB_WAYS),
        .NB_SETS(NB_SETS),
        .LINE_OFFSET(LINE_OFFSET)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus)
    );

    // Compares one observed value against the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Request mask bits: [0] enable, [1] disable, [2] flush, [3] sel_flush.
    task automatic driveReqs(input logic [3:0] m);
        bus.ctrl_req_enable_i  = m[0];
        bus.ctrl_req_disable_i = m[1];
        bus.ctrl_flush_req_i   = m[2];
        bus.sel_flush_req_i    = m[3];
    endtask

    function automatic logic [3:0] ackVec();
        return {bus.sel_flush_ack_o, bus.ctrl_flush_ack_o, bus.ctrl_ack_disable_o, bus.ctrl_ack_enable_o};
    endfunction

    // Holds every request in reqMask and serves them one by one until all are
    // acked. Bank stays busy for idleDelay cycles after each acceptance.
    // gntMode: 0 = always grant, 1 = toggle 1,0,1,0, 2 = random.
    task automatic applyStimulus(input logic [3:0] reqMask, input logic [31:0] addr,
                                 input int idleDelay, input int gntMode);
        logic [3:0] held;
        held = reqMask;
        while (held != 4'b0000) begin
            int   op;
            bit   trivial;
            bit   newEnabled;
            int   expLatency;
            int   expSets[$];
            int   granted[$];
            int   gntStalls;
            int   holdErr;
            int   earlyReq;
            int   wayErr;
            int   k;
            bit   ackSeen;
            bit   gntToggle;
            logic [3:0] ackNow;

            if (held[2])      op = 2;
            else if (held[3]) op = 3;
            else if (held[1]) op = 1;
            else              op = 0;
            trivial    = (op == 0) ? modelEnabled : !modelEnabled;
            newEnabled = (op == 0) ? 1'b1 : (op == 1) ? 1'b0 : modelEnabled;
            expSets    = {};
            granted    = {};
            if (trivial) begin
                expLatency = 1;
            end else if (op == 1) begin
                expLatency = 2 + idleDelay;
            end else if (op == 3) begin
                expLatency = 3 + idleDelay;
                expSets.push_back(int'(addr[LINE_OFFSET +: SET_W]));
            end else begin
                expLatency = NB_SETS + 2 + idleDelay;
                for (int s = 0; s < NB_SETS; s++) expSets.push_back(s);
            end

            // Cycle 0: responder idle, request presented now.
            @(negedge clk);
            checkOutput("idleHold", 32'(bus.fetch_hold_o), 32'd0);
            checkOutput("idleAck", 32'(ackVec()), 32'd0);
            checkOutput("idleTagReq", 32'(bus.tag_inv_req_o), 32'd0);
            checkOutput("enabledBefore", 32'(bus.cache_enabled_o), 32'(modelEnabled));
            driveReqs(held);
            bus.sel_flush_addr_i = addr;
            bus.bank_idle_i      = (idleDelay == 0);
            bus.tag_inv_gnt_i    = 1'b0;

            k = 0; ackSeen = 0; gntToggle = 1'b1;
            gntStalls = 0; holdErr = 0; earlyReq = 0; wayErr = 0;
            while (!ackSeen && k < BUDGET) begin
                @(negedge clk);
                k++;
                ackNow = ackVec();
                if (!bus.fetch_hold_o) holdErr++;
                if (bus.tag_inv_req_o) begin
                    if (bus.tag_inv_way_be_o != 4'hF) wayErr++;
                    if (k <= idleDelay + 1) earlyReq++;
                end
                if (ackNow != 4'b0000) begin
                    ackSeen = 1;
                    checkOutput("ackWhich", 32'(ackNow), 32'(4'b0001 << op));
                    checkOutput("ackCycle", 32'(k), 32'(expLatency + gntStalls));
                    checkOutput("enabledAfter", 32'(bus.cache_enabled_o), 32'(newEnabled));
                    checkOutput("holdLow", 32'(holdErr), 32'd0);
                    checkOutput("wayBe", 32'(wayErr), 32'd0);
                    checkOutput("earlyTagReq", 32'(earlyReq), 32'd0);
                    checkOutput("tagReqAtAck", 32'(bus.tag_inv_req_o), 32'd0);
                    checkOutput("invCount", 32'(granted.size()), 32'(expSets.size()));
                    for (int i = 0; i < granted.size() && i < expSets.size(); i++) begin
                        checkOutput("invSet", 32'(granted[i]), 32'(expSets[i]));
                    end
                    modelEnabled = newEnabled;
                    held[op] = 1'b0;
                    driveReqs(held);
                    bus.tag_inv_gnt_i = 1'b0;
                    bus.bank_idle_i   = 1'b1;
                end else begin
                    bus.sel_flush_addr_i = $urandom();
                    bus.bank_idle_i      = (k > idleDelay);
                    case (gntMode)
                        0:       bus.tag_inv_gnt_i = 1'b1;
                        1:       bus.tag_inv_gnt_i = gntToggle;
                        default: bus.tag_inv_gnt_i = ($urandom_range(0, 3) != 0);
                    endcase
                    gntToggle = ~gntToggle;
                    if (bus.tag_inv_req_o) begin
                        if (bus.tag_inv_gnt_i) granted.push_back(int'(bus.tag_inv_set_o));
                        else gntStalls++;
                    end
                end
            end
            if (!ackSeen) begin
                checkOutput("ackTimeout", 32'(k), 32'(expLatency + gntStalls));
                held = 4'b0000;
                driveReqs(held);
            end
        end
    endtask

    // Starts an enable walk from the disabled state, resets at set 10 with
    // the request still held, and expects a complete restarted walk.
    task automatic resetDuringWalk();
        int k;
        bit hit;
        @(negedge clk);
        driveReqs(4'b0001);
        bus.bank_idle_i   = 1'b1;
        bus.tag_inv_gnt_i = 1'b1;
        k = 0; hit = 0;
        while (!hit && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.tag_inv_req_o && bus.tag_inv_set_o == SET_W'(10)) hit = 1;
        end
        checkOutput("walkReachedSet10", 32'(hit), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rstHold", 32'(bus.fetch_hold_o), 32'd0);
        checkOutput("rstTagReq", 32'(bus.tag_inv_req_o), 32'd0);
        checkOutput("rstTagSet", 32'(bus.tag_inv_set_o), 32'd0);
        checkOutput("rstEnabled", 32'(bus.cache_enabled_o), 32'd0);
        checkOutput("rstAck", 32'(ackVec()), 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        modelEnabled = 1'b0;
        applyStimulus(4'b0001, 32'h0, 0, 0);
    endtask

    initial begin
        rstN = 1'b0;
        driveReqs(4'b0000);
        bus.sel_flush_addr_i = 32'h0;
        bus.bank_idle_i      = 1'b1;
        bus.tag_inv_gnt_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetHold", 32'(bus.fetch_hold_o), 32'd0);
        checkOutput("resetEnabled", 32'(bus.cache_enabled_o), 32'd0);
        checkOutput("resetTagReq", 32'(bus.tag_inv_req_o), 32'd0);
        checkOutput("resetTagSet", 32'(bus.tag_inv_set_o), 32'd0);
        checkOutput("resetAck", 32'(ackVec()), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        modelEnabled = 1'b0;

        $display("[TB] enable from reset");
        applyStimulus(4'b0001, 32'h0, 0, 0);
        $display("[TB] selective flush with busy bank");
        applyStimulus(4'b1000, 32'h0000_1230, 5, 0);
        $display("[TB] full flush with toggling grant");
        applyStimulus(4'b0100, 32'h0, 0, 1);
        $display("[TB] disable and enable together");
        applyStimulus(4'b0011, 32'h0, 0, 0);
        $display("[TB] trivial requests");
        applyStimulus(4'b0010, 32'h0, 0, 0);
        applyStimulus(4'b0100, 32'h0, 0, 0);
        applyStimulus(4'b1000, 32'hFFFF_FFF0, 0, 0);
        applyStimulus(4'b0010, 32'h0, 0, 0);
        $display("[TB] reset during walk");
        resetDuringWalk();
        applyStimulus(4'b0001, 32'h0, 0, 0);

        $display("[TB] random request mixes");
        for (int n = 0; n < 25; n++) begin
            applyStimulus(4'($urandom_range(1, 15)), $urandom(),
                          int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        checkOutput("finalAck", 32'(ackVec()), 32'd0);
        checkOutput("finalHold", 32'(bus.fetch_hold_o), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
